truth_table_capture: RTL and testbench
======================================

TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 Parameter N_IN, default 3: number of stimulus bits driven into the combinational circuit under evaluation.
REQ-002 Parameter N_OUT, default 10: number of response bits captured, with 1 <= N_OUT <= 16.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 rst  input  1: reset, asynchronous and active-high.
REQ-005 start  input  1: single-cycle request to begin one exhaustive sweep.
REQ-006 x  output  N_IN: registered stimulus vector driven to the circuit inputs (x0 = bit 0).
REQ-007 f  input  N_OUT: circuit response (f1 = bit 0), combinational from x.
REQ-008 busy  output  1: high while a sweep is in progress.
REQ-009 done  output  1: one-cycle pulse when a sweep completes.
REQ-010 rd_addr  input  N_IN: truth-table row select.
REQ-011 rd_data  output  N_OUT: captured response for row rd_addr, combinational read.
REQ-012 exp_sig  input  16: expected signature.
REQ-013 sig  output  16: current signature register.
REQ-014 match  output  1: registered flag, sig == exp_sig, updated only on sweep completion.

Function
REQ-015 FSM states: IDLE, DRIVE, SAMPLE, DONE.
REQ-016 IDLE: start=1 -> DRIVE; clear idx to 0; load sig with 16'hFFFF; assert busy from the next cycle.
REQ-017 DRIVE: register x = idx -> SAMPLE. This cycle is the settle cycle.
REQ-018 SAMPLE: table[idx] <= f; sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0) ^ zero-extended f.
REQ-019 SAMPLE transition: if idx == 2^N_IN-1 -> DONE; else idx <= idx+1 -> DRIVE.
REQ-020 idx is N_IN+1 bits wide so the final compare never wraps; x takes the low N_IN bits.
REQ-021 DONE: done=1 for exactly one cycle; match <= (sig == exp_sig) using the final sig; busy=0; -> IDLE.
REQ-022 Sweep latency: the done pulse occurs 2*2^N_IN+1 cycles after the start cycle (17 cycles for N_IN=3).
REQ-023 start while busy or in DONE is ignored; no restart or queueing.
REQ-024 start in the same cycle done is high is ignored; start is accepted only in IDLE.
REQ-025 Table, sig and match hold their values in IDLE until the next accepted start.
REQ-026 rd_data is valid for any rd_addr at any time; during a sweep, rows not yet rewritten return values from the previous sweep.
REQ-027 Rows are captured in ascending order; exactly one row is written per SAMPLE cycle.

Reset
REQ-028 Asynchronous rst forces IDLE, x=0, idx=0, busy=0, done=0, match=0, sig=16'hFFFF, and all table rows to 0.
REQ-029 rst asserted mid-sweep aborts the sweep immediately; no done pulse is produced.
REQ-030 The first start after rst deasserts is accepted normally.

Structure
REQ-031 The shared package holds the FSM state enum, SIG_SEED=16'hFFFF, SIG_POLY=16'h1021, and the function computing the next signature.
REQ-032 One sub-module, sig_misr (16-bit MISR with load, enable and data input), is instantiated once.
REQ-033 The table is a register array of 2^N_IN x N_OUT bits with no RAM macro.

Verification
REQ-034 Loopback f={7'b0,x} (N_IN=3, N_OUT=10), start pulse -> busy for 16 cycles, done at cycle 17, rd_data(k)=k for k=0..7.
REQ-035 Constant f=10'h000, exp_sig taken from the reference-model MISR over 8 zero words -> match=1; exp_sig off by one bit -> match=0.
REQ-036 Reference-style circuit (f1=f3=~(x0&x1)... as a bench model), sweep -> rd_data(3) has f1=0 and f2=1; the 8 rows equal the model's truth table.
REQ-037 start re-pulsed at cycles 5 and 17 -> both ignored; exactly one done pulse; the next start at cycle 19 runs a full sweep.
REQ-038 rst pulsed at cycle 8 of a sweep -> x=0, busy=0, sig=16'hFFFF, all rows read 0, no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/truth_table_capture_pkg.sv
// Shared types and signature arithmetic for the truth-table capture block.
package truth_table_capture_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [15:0] SIG_SEED = 16'hFFFF;
  localparam logic [15:0] SIG_POLY = 16'h1021;

  function automatic logic [15:0] sig_next(input logic [15:0] s, input logic [15:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? SIG_POLY : 16'h0000) ^ d;
  endfunction

endpackage

// File: rtl/truth_table_capture_sig_misr.sv
// 16-bit MISR: load reseeds, enable folds one data word into the signature.
module sig_misr
  import truth_table_capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_en,
  input  logic [15:0] i_data,
  output logic [15:0] o_sig
);

  logic [15:0] r_sig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_sig <= SIG_SEED;
    else if (i_load) r_sig <= SIG_SEED;
    else if (i_en)   r_sig <= sig_next(r_sig, i_data);
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps every stimulus code into a combinational circuit, captures each
// response row into a register table and compresses the responses into a MISR.
module truth_table_capture
  import truth_table_capture_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  x,
  input  logic [N_OUT-1:0] f,
  output logic             busy,
  output logic             done,
  input  logic [N_IN-1:0]  rd_addr,
  output logic [N_OUT-1:0] rd_data,
  input  logic [15:0]      exp_sig,
  output logic [15:0]      sig,
  output logic             match
);

  localparam int ROWS = 1 << N_IN;

  state_t           r_state, w_next;
  logic [N_IN:0]    r_idx;
  logic [N_IN-1:0]  r_x;
  logic [N_OUT-1:0] r_table [ROWS];
  logic             r_match;
  logic             w_last, w_load, w_en;
  logic [15:0]      w_f_ext, w_sig;

  // idx carries one extra bit so the last-row compare cannot alias to row 0
  assign w_last  = (r_idx == (N_IN+1)'(ROWS-1));
  assign w_f_ext = 16'(f);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_DRIVE;
      S_DRIVE:  w_next = S_SAMPLE;
      S_SAMPLE: w_next = w_last ? S_DONE : S_DRIVE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
    done   = (r_state == S_DONE);
    w_load = (r_state == S_IDLE) && start;
    w_en   = (r_state == S_SAMPLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_x     <= '0;
      r_match <= 1'b0;
      for (int i = 0; i < ROWS; i++) r_table[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (start) r_idx <= '0;
        S_DRIVE:  r_x <= r_idx[N_IN-1:0];
        S_SAMPLE: begin
          r_table[r_idx[N_IN-1:0]] <= f;
          if (!w_last) r_idx <= r_idx + (N_IN+1)'(1);
        end
        S_DONE:   r_match <= (w_sig == exp_sig);
        default:  ;
      endcase
    end
  end

  sig_misr u_misr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_en   (w_en),
    .i_data (w_f_ext),
    .o_sig  (w_sig)
  );

  assign x       = r_x;
  assign sig     = w_sig;
  assign match   = r_match;
  assign rd_data = r_table[rd_addr];

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench: expected values are queued as stimulus is driven and
// popped against the DUT as each sweep finishes.
module tb_truth_table_capture;
  localparam int N_IN  = 3;
  localparam int N_OUT = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [N_IN-1:0]  x;
  logic [N_OUT-1:0] f;
  logic             busy, done, match;
  logic [N_IN-1:0]  rd_addr = '0;
  logic [N_OUT-1:0] rd_data;
  logic [15:0]      exp_sig = 16'h0000;
  logic [15:0]      sig;

  int          mode  = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb[$];

  truth_table_capture #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .f(f), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .exp_sig(exp_sig), .sig(sig), .match(match)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] ref_f(input logic [2:0] v);
    logic [9:0] r;
    r[0] = ~(v[0] & v[1]);
    r[1] = v[0] | v[1];
    r[2] = ~(v[0] & v[1]);
    r[3] = v[2];
    r[4] = ^v;
    r[5] = ~v[2];
    r[6] = v[0] & v[2];
    r[7] = v[1];
    r[8] = ~(v[1] | v[2]);
    r[9] = v[0];
    return r;
  endfunction

  function automatic logic [9:0] fmodel(input int m, input logic [2:0] v);
    if (m == 0)      return {7'b0, v};
    else if (m == 1) return 10'h000;
    else             return ref_f(v);
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
    logic [16:0] t;
    t = {s, 1'b0};
    if (t[16]) t = t ^ 17'h11021;
    return t[15:0] ^ d;
  endfunction

  function automatic logic [15:0] sig_model(input int m);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int k = 0; k < 8; k++) s = misr_step(s, {6'b0, fmodel(m, 3'(k))});
    return s;
  endfunction

  always_comb f = fmodel(mode, x);

  task automatic push(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: observed %0h, scoreboard empty", tag, obs);
      return;
    end
    e = sb.pop_front();
    n_vec++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  // One start pulse, then ncyc observed cycles; optional extra start pulses and a reset pulse.
  task automatic sweep(input int rst_at, input int p1, input int p2, input int ncyc,
                       output int done_cyc, output int busy_cnt, output int done_cnt);
    done_cyc = -1; busy_cnt = 0; done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      start = (c == p1) || (c == p2);
      rst   = (c == rst_at);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic push_sweep(input int m);
    push(17); push(16); push(1);
    for (int k = 0; k < 8; k++) push({22'b0, fmodel(m, 3'(k))});
    push({16'b0, sig_model(m)});
  endtask

  task automatic run_and_check(input string name);
    int dc, bc, dn;
    sweep(0, 0, 0, 20, dc, bc, dn);
    chk({name, "_done_cycle"}, dc);
    chk({name, "_busy_cycles"}, bc);
    chk({name, "_done_count"}, dn);
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      #1;
      chk($sformatf("%s_row%0d", name, k), {22'b0, rd_data});
    end
    chk({name, "_sig"}, {16'b0, sig});
  endtask

  initial begin
    int dc, bc, dn;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    push(0); chk("rst_x", {29'b0, x});
    push(0); chk("rst_busy", {31'b0, busy});
    push(0); chk("rst_done", {31'b0, done});
    push(0); chk("rst_match", {31'b0, match});
    push(32'hFFFF); chk("rst_sig", {16'b0, sig});
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      #1;
      push(0); chk($sformatf("rst_row%0d", k), {22'b0, rd_data});
    end
    rst = 1'b0;

    // Loopback: row k reads back k
    mode = 0;
    push_sweep(0);
    run_and_check("loop");

    // All-zero responses against a matching and a one-bit-off signature
    mode = 1;
    exp_sig = sig_model(1);
    push_sweep(1); push(1);
    run_and_check("zero_match");
    chk("zero_match_flag", {31'b0, match});
    exp_sig = sig_model(1) ^ 16'h0010;
    push_sweep(1); push(0);
    run_and_check("zero_miss");
    chk("zero_miss_flag", {31'b0, match});

    // Reference-style logic circuit
    mode = 2;
    push_sweep(2);
    run_and_check("ref");
    rd_addr = 3'd3;
    #1;
    push(0); chk("ref_row3_f1", {31'b0, rd_data[0]});
    push(1); chk("ref_row3_f2", {31'b0, rd_data[1]});

    // Start re-pulsed mid-sweep and during done is ignored; restart at cycle 19
    mode = 0;
    push(17); push(16); push(1);
    sweep(0, 5, 17, 18, dc, bc, dn);
    chk("repulse_done_cycle", dc);
    chk("repulse_busy_cycles", bc);
    chk("repulse_done_count", dn);
    push_sweep(0);
    run_and_check("restart");

    // Reset mid-sweep aborts with no done and clears all state
    mode = 2;
    push(0);
    sweep(8, 0, 0, 12, dc, bc, dn);
    chk("abort_done_count", dn);
    push(0);       chk("abort_x", {29'b0, x});
    push(0);       chk("abort_busy", {31'b0, busy});
    push(32'hFFFF); chk("abort_sig", {16'b0, sig});
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      #1;
      push(0); chk($sformatf("abort_row%0d", k), {22'b0, rd_data});
    end
    push_sweep(2);
    run_and_check("post_abort");

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: observed %0d entries, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
